// File: rtl/wb_cmd_master.sv
// wb_cmd_master
// -------------
// Wishbone classic initiator. It takes one read or write command at a time
// over a valid/ready interface, runs exactly one Wishbone cycle for it (no
// pipelining, no bursts), and returns the read data or a timeout error over a
// valid/ready response interface.
//
// Parameters:
//   TIMEOUT  maximum number of edges stb may stay high without an ack (1..65535)
//   CNT_W    width of txn_count
//
// Ports:
//   wb_clk_i, wb_rst_i       clock (rising edge), asynchronous active-high reset
//   cmd_valid / cmd_ready    command handshake
//   cmd_we, cmd_adr,
//   cmd_dat, cmd_sel         command contents (write enable, byte address,
//                            write data, byte lane selects)
//   rsp_valid / rsp_ready    response handshake
//   rsp_dat, rsp_err         read data (0 for writes and errors), timeout flag
//   wbm_cyc_o .. wbm_dat_o   Wishbone initiator outputs
//   wbm_ack_i, wbm_dat_i     Wishbone responder inputs
//   txn_count                number of responses consumed, errors included;
//                            wraps at 2^CNT_W
module wb_cmd_master #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_adr,
    input  logic [31:0]      cmd_dat,
    input  logic [3:0]       cmd_sel,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_dat,
    output logic             rsp_err,

    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i,

    output logic [CNT_W-1:0] txn_count
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_t;

    // The wait counter holds the number of ack-less edges seen so far in BUS,
    // so the timeout fires on the edge where that number would reach TIMEOUT.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [15:0] wait_cnt;

    // Single control process. Every output is a register, so cyc/stb fall
    // asynchronously with reset and nothing glitches combinationally.
    // cmd_ready comes up one edge after reset release because it is only set
    // from within IDLE; a command is taken only when cmd_ready was already
    // high at the edge, which keeps the handshake honest.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            txn_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready <= 1'b0;
                        wbm_we_o  <= cmd_we;
                        wbm_adr_o <= cmd_adr;
                        wbm_dat_o <= cmd_dat;
                        wbm_sel_o <= cmd_sel;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= BUS;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end

                BUS: begin
                    // An ack on the timeout edge still counts as success.
                    if (wbm_ack_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= wbm_we_o ? 32'h0 : wbm_dat_i;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        rsp_dat   <= 32'h0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end

                RESP: begin
                    // Response fields hold until consumed; readiness for the
                    // next command returns on the consuming edge.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        txn_count <= txn_count + CNT_W'(1);
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master
// ----------------
// Directed bench for wb_cmd_master with TIMEOUT=4 and a 3-bit txn_count so
// that wrap-around is reachable. A transaction-level model predicts every
// output and is compared on each falling edge; the directed tests add
// hand-computed literal expectations on top.
module tb_wb_cmd_master;

    localparam int TO = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [31:0]   cmd_adr = '0;
    logic [31:0]   cmd_dat = '0;
    logic [3:0]    cmd_sel = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_dat;
    logic          rsp_err;
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [3:0]    wbm_sel_o;
    logic [31:0]   wbm_adr_o;
    logic [31:0]   wbm_dat_o;
    logic          wbm_ack_i;
    logic [31:0]   wbm_dat_i = '0;
    logic [CW-1:0] txn_count;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wb_cmd_master #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_dat_i (wbm_dat_i),
        .txn_count (txn_count)
    );

    // Every comparison goes through here so the counts stay honest.
    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Responder: acks during the ack_at-th cycle of stb (0 = never), plus an
    // optional stray pulse driven directly by the stimulus.
    int   ack_at    = 0;
    int   stb_cycle = 0;
    logic resp_ack  = 1'b0;
    logic force_ack = 1'b0;
    assign wbm_ack_i = resp_ack | force_ack;

    always @(posedge clk) begin
        #1;
        if (wbm_stb_o) stb_cycle = stb_cycle + 1;
        else           stb_cycle = 0;
        resp_ack = wbm_stb_o && (ack_at != 0) && (stb_cycle == ack_at);
    end

    // Transaction-level model: the master is either waiting for a command,
    // running a bus cycle of a known age, or holding a response.
    logic        m_ready = 1'b0;
    logic        m_busy  = 1'b0;
    int          m_age   = 0;
    logic        m_we    = 1'b0;
    logic [3:0]  m_sel   = '0;
    logic [31:0] m_adr   = '0;
    logic [31:0] m_wdat  = '0;
    logic        m_rv    = 1'b0;
    logic [31:0] m_rd    = '0;
    logic        m_re    = 1'b0;
    int          m_count = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready = 0; m_busy = 0; m_age = 0; m_we = 0; m_sel = '0;
            m_adr = '0; m_wdat = '0; m_rv = 0; m_rd = '0; m_re = 0; m_count = 0;
        end else if (m_rv) begin
            if (rsp_ready) begin
                m_rv    = 0;
                m_count = (m_count + 1) % (1 << CW);
                m_ready = 1;
            end
        end else if (m_busy) begin
            m_age = m_age + 1;
            if (wbm_ack_i) begin
                m_busy = 0; m_rv = 1; m_re = 0;
                m_rd   = m_we ? 32'h0 : wbm_dat_i;
            end else if (m_age == TO) begin
                m_busy = 0; m_rv = 1; m_re = 1; m_rd = 32'h0;
            end
        end else if (m_ready && cmd_valid) begin
            m_ready = 0; m_busy = 1; m_age = 0;
            m_we = cmd_we; m_adr = cmd_adr; m_wdat = cmd_dat; m_sel = cmd_sel;
        end else begin
            m_ready = 1;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        check_output("cmd_ready", 32'(cmd_ready), 32'(m_ready));
        check_output("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        check_output("rsp_dat",   rsp_dat,        m_rd);
        check_output("rsp_err",   32'(rsp_err),   32'(m_re));
        check_output("cyc",       32'(wbm_cyc_o), 32'(m_busy));
        check_output("stb",       32'(wbm_stb_o), 32'(m_busy));
        check_output("we",        32'(wbm_we_o),  32'(m_we));
        check_output("sel",       32'(wbm_sel_o), 32'(m_sel));
        check_output("adr",       wbm_adr_o,      m_adr);
        check_output("dat_o",     wbm_dat_o,      m_wdat);
        check_output("txn_count", 32'(txn_count), 32'(m_count));
    end

    // Issue one command, wait for its response, hold rsp_ready low for
    // `hold` cycles (with optional stray ack and junk command), then consume.
    task automatic apply_stimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                  input logic [3:0] sel, input int ack_cycle, input logic [31:0] rdata,
                                  input int hold, input logic stray,
                                  output int stb_len, output int lat,
                                  output logic [31:0] rd, output logic re);
        int n;
        stb_len = 0; lat = 0; rd = '0; re = 1'b0;
        @(negedge clk);
        cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        ack_at = ack_cycle; wbm_dat_i = rdata; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check_output("accept_wait", 32'(cmd_ready), 32'h1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_adr = 32'h0BAD_0BAD; cmd_dat = 32'hFFFF_0000; cmd_we = ~we;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (wbm_stb_o) stb_len++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) check_output("rsp_wait", 32'(rsp_valid), 32'h1);
        rd = rsp_dat; re = rsp_err;
        for (int i = 0; i < hold; i++) begin
            force_ack = stray && (i == 4);
            cmd_valid = stray && (i > 1) && (i < 8);
            @(negedge clk);
            check_output("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            check_output("bp_rsp_dat",   rsp_dat,        rd);
            check_output("bp_rsp_err",   32'(rsp_err),   32'(re));
            check_output("bp_cmd_ready", 32'(cmd_ready), 32'h0);
            check_output("bp_stb",       32'(wbm_stb_o), 32'h0);
        end
        force_ack = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    int          s_len, s_lat;
    logic [31:0] s_rd;
    logic        s_re;

    initial begin
        repeat (3) @(negedge clk);
        check_output("reset_cmd_ready", 32'(cmd_ready), 32'h0);
        check_output("reset_txn_count", 32'(txn_count), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_output("ready_after_release", 32'(cmd_ready), 32'h1);

        // Write acked on the second stb cycle.
        apply_stimulus(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 2, 32'h1111_2222, 0, 1'b0,
                       s_len, s_lat, s_rd, s_re);
        check_output("wr_stb_len", 32'(s_len), 32'd2);
        check_output("wr_rsp_dat", s_rd, 32'h0);
        check_output("wr_rsp_err", 32'(s_re), 32'h0);
        check_output("wr_adr_kept", wbm_adr_o, 32'h3000_0004);
        check_output("wr_dat_kept", wbm_dat_o, 32'hA5A5_1234);
        check_output("wr_txn_count", 32'(txn_count), 32'd1);

        // Read acked in the first cycle.
        apply_stimulus(1'b0, 32'h300F_FFF8, 32'h0, 4'hF, 1, 32'hDEAD_BEEF, 0, 1'b0,
                       s_len, s_lat, s_rd, s_re);
        check_output("rd_rsp_dat", s_rd, 32'hDEAD_BEEF);
        check_output("rd_rsp_err", 32'(s_re), 32'h0);
        check_output("rd_latency", 32'(s_lat), 32'd2);

        // Timeout with no ack.
        apply_stimulus(1'b0, 32'h3000_0100, 32'h0, 4'h3, 0, 32'h5555_AAAA, 0, 1'b0,
                       s_len, s_lat, s_rd, s_re);
        check_output("to_stb_len", 32'(s_len), 32'd4);
        check_output("to_rsp_err", 32'(s_re), 32'h1);
        check_output("to_rsp_dat", s_rd, 32'h0);
        check_output("to_txn_count", 32'(txn_count), 32'd3);

        // Ack on the timeout edge wins.
        apply_stimulus(1'b0, 32'h3000_0200, 32'h0, 4'hC, 4, 32'h1234_5678, 0, 1'b0,
                       s_len, s_lat, s_rd, s_re);
        check_output("ackto_stb_len", 32'(s_len), 32'd4);
        check_output("ackto_rsp_err", 32'(s_re), 32'h0);
        check_output("ackto_rsp_dat", s_rd, 32'h1234_5678);

        // Backpressure with stray ack and junk command during RESP.
        apply_stimulus(1'b0, 32'h3000_0300, 32'h0, 4'hF, 1, 32'hCAFE_F00D, 10, 1'b1,
                       s_len, s_lat, s_rd, s_re);
        check_output("bp_final_dat", s_rd, 32'hCAFE_F00D);
        check_output("bp_txn_count", 32'(txn_count), 32'd5);

        // Asynchronous reset in the middle of a bus cycle.
        @(negedge clk);
        cmd_we = 1'b1; cmd_adr = 32'h3000_0400; cmd_dat = 32'h0F0F_0F0F; cmd_sel = 4'hF;
        ack_at = 0; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #2;
        check_output("pre_reset_stb", 32'(wbm_stb_o), 32'h1);
        rst = 1'b1;
        #1;
        check_output("async_cyc", 32'(wbm_cyc_o), 32'h0);
        check_output("async_stb", 32'(wbm_stb_o), 32'h0);
        check_output("async_rsp_valid", 32'(rsp_valid), 32'h0);
        check_output("async_txn_count", 32'(txn_count), 32'h0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;

        apply_stimulus(1'b0, 32'h3000_0008, 32'h0, 4'hF, 1, 32'h0000_BEEF, 0, 1'b0,
                       s_len, s_lat, s_rd, s_re);
        check_output("post_reset_dat", s_rd, 32'h0000_BEEF);
        check_output("post_reset_count", 32'(txn_count), 32'd1);

        // Seven more pushes the 3-bit counter from 1 through 7 and wraps to 0.
        for (int k = 0; k < 7; k++) begin
            apply_stimulus(1'b1, 32'h3000_1000 + 32'(k * 4), 32'(k), 4'h1, 1, 32'h0, 0, 1'b0,
                           s_len, s_lat, s_rd, s_re);
        end
        check_output("wrap_txn_count", 32'(txn_count), 32'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
